// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock, LSB chunk first.
// Optional saturation of the signed result is enabled by defining SEQ_CHUNK_ADDER_SAT_EN.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("seq_chunk_adder: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic [CW-1:0]                cnt_r;
    logic [NCHUNK-1:0][CHUNK-1:0] a_r;
    logic [NCHUNK-1:0][CHUNK-1:0] b_r;
    logic [NCHUNK-1:0][CHUNK-1:0] work_r;
    logic [NCHUNK-1:0][CHUNK-1:0] work_nxt_s;
    logic                         carry_r;
    logic                         accept_s;
    logic                         last_s;
    logic [CHUNK-1:0]             chunk_a_s;
    logic [CHUNK-1:0]             chunk_b_s;
    logic [CHUNK-1:0]             chunk_sum_s;
    logic                         chunk_cout_s;
    logic                         msb_cin_s;
    logic                         ovf_s;
    logic [WIDTH-1:0]             result_s;

    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_s   = (cnt_r == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Chunk slice adder; the MSB carry-in is recovered from the sum bit and its operands
    always_comb begin
        chunk_a_s  = a_r[cnt_r];
        chunk_b_s  = b_r[cnt_r];
        {chunk_cout_s, chunk_sum_s} = {1'b0, chunk_a_s} + {1'b0, chunk_b_s}
                                    + {{CHUNK{1'b0}}, carry_r};
        msb_cin_s  = chunk_sum_s[CHUNK-1] ^ chunk_a_s[CHUNK-1] ^ chunk_b_s[CHUNK-1];
        ovf_s      = msb_cin_s ^ chunk_cout_s;
        work_nxt_s = work_r;
        work_nxt_s[cnt_r] = chunk_sum_s;
    end

    // Final result selection (wrapped or saturated)
    always_comb begin
        result_s = work_nxt_s;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
        if (ovf_s) begin
            if (!a_r[NCHUNK-1][CHUNK-1] && !b_r[NCHUNK-1][CHUNK-1]) begin
                result_s = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                result_s = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            result_s = work_nxt_s;
        end
`endif
    end

    // Operand capture and per-chunk working state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            work_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (accept_s) begin
            // Subtraction runs as a + ~b + ~cin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= cin ^ sub;
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == ST_BUSY) begin
            work_r  <= work_nxt_s;
            carry_r <= chunk_cout_s;
            cnt_r   <= last_s ? {CW{1'b0}} : (cnt_r + CNT_ONE);
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // Result outputs, loaded only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= {WIDTH{1'b0}};
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if ((state_r == ST_BUSY) && last_s) begin
            sum      <= result_s;
            cout     <= chunk_cout_s;
            overflow <= ovf_s;
        end else begin
            sum      <= sum;
        end
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt_s == ST_BUSY);
            done <= (state_nxt_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4): directed table, corner sequences, random ops.
module tb_seq_chunk_adder;

    localparam int W  = 16;
    localparam int NC = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] held_exp;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: whole-word integer arithmetic
    task automatic model(input logic s_sub, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, output logic [W-1:0] rs, output logic rco, output logic rov);
        int u;
        int sr;
        int sa;
        int sb;
        sa = $signed(va);
        sb = $signed(vb);
        if (!s_sub) begin
            u   = int'(va) + int'(vb) + int'(vc);
            rco = (u > 65535);
            sr  = sa + sb + int'(vc);
        end else begin
            u   = int'(va) - int'(vb) - int'(vc);
            rco = (u >= 0);
            sr  = sa - sb - int'(vc);
        end
        rs  = u[W-1:0];
        rov = (sr > 32767) || (sr < -32768);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
        if (rov) rs = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch an op from a post-edge slot; returns in the DONE cycle with start low
    task automatic run_op(input logic s_sub, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic hold, input string tag);
        int n;
        logic [W-1:0] es;
        logic eco;
        logic eov;
        model(s_sub, va, vb, vc, es, eco, eov);
        sub = s_sub; a = va; b = vb; cin = vc; start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            chk({tag, "_busy_done_excl"}, {31'd0, done}, 32'd0);
            chk({tag, "_sum_held"}, {16'd0, sum}, {16'd0, held_exp});
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            step();
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, n, NC);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, eco});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eov});
        held_exp = es;
    endtask

    task automatic idle_check(input string tag);
        step();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_sum"}, {16'd0, sum}, {16'd0, held_exp});
    endtask

    initial begin
        vec_t vecs[6];
        logic [W-1:0] first_sum;
        vecs[0] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
`ifdef SEQ_CHUNK_ADDER_SAT_EN
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
`endif
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
        held_exp = 16'h0000;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed table: independent constants, also cross-checks the model
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ms;
            logic mco;
            logic mov;
            model(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, ms, mco, mov);
            chk($sformatf("vec%0d_model", i), {15'd0, ms, mco}, {15'd0, vecs[i].s, vecs[i].co});
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tsum", i), {16'd0, sum}, {16'd0, vecs[i].s});
            chk($sformatf("vec%0d_tcout", i), {31'd0, cout}, {31'd0, vecs[i].co});
            chk($sformatf("vec%0d_tovf", i), {31'd0, overflow}, {31'd0, vecs[i].ov});
            idle_check($sformatf("vec%0d", i));
        end

        // Reset in the middle of an operation
        sub = 1'b0; a = 16'hAAAA; b = 16'h1111; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        held_exp = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("postrst_idle", {31'd0, busy}, 32'd0);
        run_op(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, "postrst");
        chk("postrst_const", {16'd0, sum}, 32'h0000_2345);
        idle_check("postrst");

        // start held through BUSY is ignored; operands scrambled after capture
        run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b1, "hold");
        chk("hold_const", {16'd0, sum}, 32'h0000_1000);
        idle_check("hold");

        // Back-to-back: new start in the DONE cycle
        run_op(1'b0, 16'h0101, 16'h0202, 1'b0, 1'b0, "b2b1");
        first_sum = held_exp;
        run_op(1'b1, 16'h0400, 16'h0001, 1'b1, 1'b0, "b2b2");
        chk("b2b_first_const", {16'd0, first_sum}, 32'h0000_0303);
        chk("b2b_second_const", {16'd0, sum}, 32'h0000_03FE);
        idle_check("b2b2");

        // Random operations, some chained back-to-back
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) idle_check($sformatf("rnd%0d", i));
        end
        idle_check("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
